efuse_prog_ctrl: RTL and testbench

- Parametrised eFuse macro controller; drives the CSB/PGM/SCLK/DIN serial interface of the fuse macro from the 1 MHz domain.
- Supports three modes: program, read, and program-then-verify.
- Read-back bits are captured from DOUT into a parallel register.
- Has a start/busy/done handshake to the slow-control register block, replacing free-running one-shot sequencing.

---
 rtl/efuse_pkg.sv | 27 ++
 rtl/efuse_slot_timer.sv | 47 ++++
 rtl/efuse_prog_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_efuse_prog_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse macro controller: mode encodings, FSM states
// and a constant-width helper.
package efuse_pkg;

    localparam logic [1:0] MODE_READ        = 2'b00;
    localparam logic [1:0] MODE_PROG        = 2'b01;
    localparam logic [1:0] MODE_PROG_VERIFY = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        P_SETUP,
        P_BIT,
        P_HOLD,
        R_SETUP,
        R_BIT,
        R_HOLD,
        FIN
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/efuse_slot_timer.sv
// Phase/slot timer: counts cycles within a phase or bit slot and, in bit mode,
// advances the bit index once per slot. Reloaded by the FSM on every phase change.
module efuse_slot_timer
    import efuse_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int CW    = 6,
    parameter int BW    = clog2(NBITS) + 1
) (
    input  logic          clk_1M,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_len,
    input  logic          load_bits,
    output logic [CW-1:0] k,
    output logic          slot_last,
    output logic [BW-1:0] bit_idx,
    output logic          last_bit
);

    logic [CW-1:0] lim;
    logic          bits_en;

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            k       <= '0;
            lim     <= '0;
            bit_idx <= '0;
            bits_en <= 1'b0;
        end else if (load) begin
            k       <= '0;
            lim     <= load_len - CW'(1);
            bit_idx <= '0;
            bits_en <= load_bits;
        end else if (slot_last) begin
            k <= '0;
            // index parks on the last bit so it never wraps
            if (bits_en && !last_bit) bit_idx <= bit_idx + 1'b1;
        end else begin
            k <= k + 1'b1;
        end
    end

    assign slot_last = (k == lim);
    assign last_bit  = (bit_idx == BW'(NBITS - 1));

endmodule

// File: rtl/efuse_prog_ctrl.sv
// eFuse macro controller: sequences CSB/PGM/SCLK for program, read and
// program-then-verify operations behind a start/busy/done handshake.
module efuse_prog_ctrl
    import efuse_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int BIT_CYC    = 8,
    parameter int PULSE_CYC  = 4,
    parameter int CSB_SETUP  = 25,
    parameter int CSB_HOLD   = 25,
    parameter int READ_SETUP = 30
) (
    input  logic             clk_1M,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] prog_data,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] read_data,
    output logic             verify_err,
    output logic             CSB,
    output logic             PGM,
    output logic             SCLK,
    output logic             DIN,
    input  logic             DOUT
);

    localparam int MAX_A = (CSB_SETUP > CSB_HOLD) ? CSB_SETUP : CSB_HOLD;
    localparam int MAX_B = (READ_SETUP > BIT_CYC) ? READ_SETUP : BIT_CYC;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = clog2(MAXC) + 1;
    localparam int BW    = clog2(NBITS) + 1;

    state_t           state, state_nxt;
    logic [1:0]       mode_q;
    logic [NBITS-1:0] prog_q;

    logic             load;
    logic [CW-1:0]    load_len;
    logic             load_bits;
    logic [CW-1:0]    k;
    logic             slot_last;
    logic [BW-1:0]    bit_idx;
    logic             last_bit;

    logic             pgm_bit;
    logic             in_pulse;
    logic             accept;

    efuse_slot_timer #(
        .NBITS (NBITS),
        .CW    (CW),
        .BW    (BW)
    ) u_timer (
        .clk_1M    (clk_1M),
        .rst       (rst),
        .load      (load),
        .load_len  (load_len),
        .load_bits (load_bits),
        .k         (k),
        .slot_last (slot_last),
        .bit_idx   (bit_idx),
        .last_bit  (last_bit)
    );

    assign accept   = (state == IDLE) && start;
    assign in_pulse = (k >= CW'(1)) && (k <= CW'(PULSE_CYC));
    assign DIN      = 1'b0;

    always_comb begin
        pgm_bit = 1'b0;
        for (int j = 0; j < NBITS; j++) begin
            if (bit_idx == BW'(j)) pgm_bit = prog_q[j];
        end
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= MODE_READ;
            read_data  <= '0;
            verify_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_q     <= mode;
                verify_err <= 1'b0;
            end
            // DOUT is sampled on the last cycle of each read slot
            if (state == R_BIT && slot_last) begin
                for (int j = 0; j < NBITS; j++) begin
                    if (bit_idx == BW'(j)) read_data[j] <= DOUT;
                end
            end
            if (state == R_HOLD && slot_last) begin
                verify_err <= (mode_q == MODE_PROG_VERIFY) && (read_data != prog_q);
            end
        end
    end

    always_ff @(posedge clk_1M) begin
        if (accept) prog_q <= prog_data;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_len  = '0;
        load_bits = 1'b0;
        CSB       = 1'b1;
        PGM       = 1'b0;
        SCLK      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (mode == MODE_PROG || mode == MODE_PROG_VERIFY) begin
                        state_nxt = P_SETUP;
                        load_len  = CW'(CSB_SETUP);
                    end else begin
                        state_nxt = R_SETUP;
                        load_len  = CW'(READ_SETUP);
                    end
                end
            end
            P_SETUP: begin
                busy = 1'b1;
                CSB  = !slot_last;
                if (slot_last) begin
                    state_nxt = P_BIT;
                    load      = 1'b1;
                    load_len  = CW'(BIT_CYC);
                    load_bits = 1'b1;
                end
            end
            P_BIT: begin
                busy = 1'b1;
                CSB  = 1'b0;
                PGM  = pgm_bit;
                SCLK = in_pulse;
                if (slot_last && last_bit) begin
                    state_nxt = P_HOLD;
                    load      = 1'b1;
                    load_len  = CW'(CSB_HOLD);
                end
            end
            P_HOLD: begin
                busy = 1'b1;
                CSB  = 1'b0;
                if (slot_last) begin
                    if (mode_q == MODE_PROG_VERIFY) begin
                        state_nxt = R_SETUP;
                        load      = 1'b1;
                        load_len  = CW'(READ_SETUP);
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            R_SETUP: begin
                busy = 1'b1;
                SCLK = 1'b1;
                if (slot_last) begin
                    state_nxt = R_BIT;
                    load      = 1'b1;
                    load_len  = CW'(BIT_CYC);
                    load_bits = 1'b1;
                end
            end
            R_BIT: begin
                busy = 1'b1;
                CSB  = 1'b0;
                SCLK = !in_pulse;
                if (slot_last && last_bit) begin
                    state_nxt = R_HOLD;
                    load      = 1'b1;
                    load_len  = CW'(CSB_HOLD);
                end
            end
            R_HOLD: begin
                busy = 1'b1;
                CSB  = 1'b0;
                SCLK = 1'b1;
                if (slot_last) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_efuse_prog_ctrl.sv
// Bench for efuse_prog_ctrl: a fuse-macro model on the serial pins, and a
// phase-list reference of the expected pin/handshake trace checked every cycle.
module tb_efuse_prog_ctrl;

    localparam int NB = 32;
    localparam int BC = 8;
    localparam int PC = 4;
    localparam int CS = 25;
    localparam int CH = 25;
    localparam int RS = 30;
    localparam int LP = CS + NB * BC + CH;
    localparam int LR = RS + NB * BC + CH;

    logic          clk_1M = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [NB-1:0] prog_data = '0;
    logic          busy, done, verify_err, CSB, PGM, SCLK, DIN;
    logic [NB-1:0] read_data;
    logic          DOUT = 1'b0;

    efuse_prog_ctrl #(
        .NBITS(NB), .BIT_CYC(BC), .PULSE_CYC(PC),
        .CSB_SETUP(CS), .CSB_HOLD(CH), .READ_SETUP(RS)
    ) dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .prog_data  (prog_data),
        .busy       (busy),
        .done       (done),
        .read_data  (read_data),
        .verify_err (verify_err),
        .CSB        (CSB),
        .PGM        (PGM),
        .SCLK       (SCLK),
        .DIN        (DIN),
        .DOUT       (DOUT)
    );

    always #5 clk_1M = ~clk_1M;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- fuse macro model ----------------
    logic [NB-1:0] fuse = '0;
    logic [NB-1:0] fuse_init = '0;
    logic [NB-1:0] stuck = '0;
    logic          load_fuse = 1'b0;
    logic          csb_prev = 1'b1;
    logic          sclk_prev = 1'b0;
    int            pcnt = 0;
    int            rcnt = 0;

    always @(negedge clk_1M) begin
        if (load_fuse) fuse = fuse_init;
        if (csb_prev && !CSB) begin
            pcnt = 0;
            rcnt = 0;
        end
        if (!CSB && SCLK && !sclk_prev) begin
            if (PGM && pcnt < NB) begin
                if (!stuck[pcnt]) fuse[pcnt] = 1'b1;
            end
            pcnt++;
        end
        if (!CSB && !SCLK && sclk_prev && rcnt < NB) begin
            DOUT = fuse[rcnt];
            rcnt++;
        end
        csb_prev  = CSB;
        sclk_prev = SCLK;
    end

    // ---------------- reference trace ----------------
    typedef struct {
        logic          csb, pgm, sclk, busy, done, verr, chk_rd;
        logic [NB-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    logic [NB-1:0] rd_m = '0;
    logic          verr_m = 1'b0;
    int            mb_cnt = 0;

    task automatic push(input logic c, input logic p, input logic s, input logic b,
                        input logic d, input logic v, input logic cr, input logic [NB-1:0] r);
        exp_t e;
        e.csb = c; e.pgm = p; e.sclk = s; e.busy = b;
        e.done = d; e.verr = v; e.chk_rd = cr; e.rd = r;
        exp_q.push_back(e);
    endtask

    task automatic build(input logic [1:0] m, input logic [NB-1:0] p);
        logic          isprog, isread, vf, pulse;
        logic [NB-1:0] nf, rdf;
        int            len0;
        isprog = (m == 2'b01) || (m == 2'b10);
        isread = (m != 2'b01);
        nf     = isprog ? (fuse | (p & ~stuck)) : fuse;
        rdf    = isread ? nf : rd_m;
        vf     = (m == 2'b10) && (nf != p);
        len0   = exp_q.size();
        if (isprog) begin
            for (int j = 0; j < CS; j++) push((j == CS - 1) ? 1'b0 : 1'b1, 0, 0, 1, 0, 0, 1, rd_m);
            for (int i = 0; i < NB; i++)
                for (int kk = 0; kk < BC; kk++) begin
                    pulse = (kk >= 1) && (kk <= PC);
                    push(0, p[i], pulse, 1, 0, 0, 1, rd_m);
                end
            for (int j = 0; j < CH; j++) push(0, 0, 0, 1, 0, 0, 1, rd_m);
        end
        if (isread) begin
            for (int j = 0; j < RS; j++) push(1, 0, 1, 1, 0, 0, 1, rd_m);
            for (int i = 0; i < NB; i++)
                for (int kk = 0; kk < BC; kk++) begin
                    pulse = (kk >= 1) && (kk <= PC);
                    push(0, 0, !pulse, 1, 0, 0, 0, rd_m);
                end
            for (int j = 0; j < CH; j++) push(0, 0, 1, 1, 0, 0, 1, rdf);
        end
        push(1, 0, 0, 0, 1, vf, 1, rdf);
        mb_cnt = exp_q.size() - len0 + 1;
        rd_m   = rdf;
        verr_m = vf;
    endtask

    always @(posedge clk_1M) begin
        if (rst) begin
            exp_q.delete();
            rd_m   = '0;
            verr_m = 1'b0;
            mb_cnt = 0;
        end else begin
            if (mb_cnt > 0) mb_cnt--;
            if (start && mb_cnt == 0) build(mode, prog_data);
        end
    end

    always @(negedge clk_1M) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.csb = 1; e.pgm = 0; e.sclk = 0; e.busy = 0; e.done = 0;
            e.verr = verr_m; e.chk_rd = 1; e.rd = rd_m;
        end
        chk("CSB", CSB, e.csb);
        chk("PGM", PGM, e.pgm);
        chk("SCLK", SCLK, e.sclk);
        chk("DIN", DIN, 1'b0);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("verify_err", verify_err, e.verr);
        if (e.chk_rd) chk("read_data", read_data, e.rd);
    end

    // ---------------- stimulus ----------------
    task automatic set_fuse(input logic [NB-1:0] v, input logic [NB-1:0] s);
        fuse_init = v & ~s;
        stuck     = s;
        load_fuse = 1'b1;
        @(negedge clk_1M);
        @(negedge clk_1M);
        load_fuse = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] m, input logic [NB-1:0] p, input int inj,
                         input int rst_at, output int nb, output int nd);
        @(negedge clk_1M);
        start = 1'b1; mode = m; prog_data = p;
        nb = 0; nd = 0;
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk_1M);
            start = (c == inj);
            if (c == inj) mode = 2'b00;
            rst = (c == rst_at);
            if (busy) nb++;
            if (done) nd++;
            if (done || (rst_at > 0 && c > rst_at + 3)) break;
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk_1M);
    endtask

    initial begin
        int nb, nd;
        repeat (3) @(negedge clk_1M);
        rst = 1'b0;
        chk("reset_read_data", read_data, 0);
        chk("reset_CSB", CSB, 1);
        chk("reset_busy", busy, 0);

        set_fuse(32'h1234_5678, '0);
        do_op(2'b00, '0, 0, 0, nb, nd);
        chk("read_busy_len", nb, 311);
        chk("read_done_cnt", nd, 1);
        chk("read_value", read_data, 32'h1234_5678);

        set_fuse('0, '0);
        do_op(2'b01, 32'hA5A5_0F0F, 0, 0, nb, nd);
        chk("prog_busy_len", nb, 306);
        chk("prog_done_cnt", nd, 1);
        chk("prog_fuse", fuse, 32'hA5A5_0F0F);
        chk("prog_read_data_kept", read_data, 32'h1234_5678);

        set_fuse('0, '0);
        do_op(2'b10, 32'hDEAD_BEEF, 0, 0, nb, nd);
        chk("verify_busy_len", nb, 617);
        chk("verify_ok_err", verify_err, 0);
        chk("verify_ok_data", read_data, 32'hDEAD_BEEF);

        set_fuse('0, 32'h0000_0080);
        do_op(2'b10, 32'hDEAD_BEEF, 0, 0, nb, nd);
        chk("verify_stuck_err", verify_err, 1);
        chk("verify_stuck_bit7", read_data[7], 0);
        chk("verify_stuck_data", read_data, 32'hDEAD_BE6F);

        set_fuse('0, '0);
        do_op(2'b01, 32'hA5A5_0F0F, 100, 0, nb, nd);
        chk("midstart_busy_len", nb, 306);
        chk("midstart_done_cnt", nd, 1);
        chk("midstart_fuse", fuse, 32'hA5A5_0F0F);

        set_fuse('0, '0);
        do_op(2'b01, 32'hFFFF_FFFF, 0, CS + 10 * BC + 1, nb, nd);
        chk("abort_done_cnt", nd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_CSB", CSB, 1);
        chk("abort_fuse", fuse, 32'h0000_03FF);
        do_op(2'b00, '0, 0, 0, nb, nd);
        chk("after_abort_len", nb, 311);
        chk("after_abort_read", read_data, 32'h0000_03FF);

        for (int t = 0; t < 14; t++) begin
            logic [1:0]    m;
            logic [NB-1:0] p, s;
            int            inj, el;
            m  = 2'($urandom_range(0, 3));
            p  = $urandom;
            s  = ($urandom_range(0, 2) == 0) ? (NB'(1) << $urandom_range(0, NB - 1)) : '0;
            set_fuse($urandom & $urandom, s);
            el  = (m == 2'b01) ? LP : (m == 2'b10) ? LP + LR : LR;
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, el - 3)) : 0;
            do_op(m, p, inj, 0, nb, nd);
            chk("rand_busy_len", nb, el);
            chk("rand_done_cnt", nd, 1);
            repeat ($urandom_range(0, 4)) @(negedge clk_1M);
        end

        repeat (3) @(negedge clk_1M);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
